// File: rtl/nn_fixed_pkg.sv
// Fixed-point activation and pixel formats shared by the normalise and denormalise stages.
// Activations are signed Q8.7 (value = pixel * 128); pixels are unsigned bytes.
package nn_fixed_pkg;
    localparam int PIX_W           = 8;
    localparam int ACT_W           = 16;
    localparam int ACT_FRAC        = 7;
    localparam int FRAME_LEN_MNIST = 784;

    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic signed [ACT_W-1:0] act_t;
endpackage

// File: rtl/pipe_reg.sv
// One-entry valid/ready register slice, 1-cycle latency.
// Accepts when empty or draining in the same cycle; holds data stable while stalled.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);
    assign s_ready = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) begin
                m_data <= s_data;
            end
        end
    end
endmodule

// File: rtl/denormalize.sv
// Round-half-up and clamp of signed fixed-point activations to unsigned pixels; 2-cycle latency, full backpressure.
// Counts elements per frame for m_last/frame_done; DENORM_SAT_CNT_EN adds a per-frame clamp counter (sat_count).
module denormalize
    import nn_fixed_pkg::*;
#(
    parameter int IN_W      = ACT_W,
    parameter int FRAC_BITS = ACT_FRAC,
    parameter int OUT_W     = PIX_W,
    parameter int FRAME_LEN = FRAME_LEN_MNIST,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OUT_W-1:0]       m_data,
    output logic                   m_last,
`ifdef DENORM_SAT_CNT_EN
    output logic [15:0]            sat_count,
`endif
    output logic                   frame_done
);
    // One guard bit so +32767 plus the rounding half cannot wrap.
    localparam int R_W = IN_W + 1;
    localparam int CW  = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic signed [R_W-1:0] HALF    = R_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [R_W-1:0] PIX_MAX = R_W'(2 ** OUT_W - 1);
    localparam logic [CW-1:0]         LAST_IDX = CW'(FRAME_LEN - 1);

    typedef struct packed {
        logic [OUT_W-1:0] pix;
`ifdef DENORM_SAT_CNT_EN
        logic             clamp;
`endif
    } s2_t;

    logic signed [R_W-1:0] r1_d;
    logic [R_W-1:0]        r1;
    logic                  v1;
    logic                  rdy2;
    logic signed [R_W-1:0] q;
    s2_t                   s2_d;
    s2_t                   s2_q;

    assign r1_d = $signed({s_data[IN_W-1], s_data}) + HALF;

    pipe_reg #(.W(R_W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (r1_d),
        .m_valid (v1),
        .m_ready (rdy2),
        .m_data  (r1)
    );

    assign q = $signed(r1) >>> FRAC_BITS;

    always_comb begin
        s2_d = '0;
        if (q[R_W-1]) begin
            s2_d.pix = '0;
        end else if (q > PIX_MAX) begin
            s2_d.pix = '1;
        end else begin
            s2_d.pix = q[OUT_W-1:0];
        end
`ifdef DENORM_SAT_CNT_EN
        s2_d.clamp = q[R_W-1] || (q > PIX_MAX);
`endif
    end

    pipe_reg #(.W($bits(s2_t))) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (v1),
        .s_ready (rdy2),
        .s_data  (s2_d),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (s2_q)
    );

    assign m_data = s2_q.pix;

    logic [CW-1:0] cnt;
    logic          hs;
    logic          at_last;

    assign hs      = m_valid && m_ready;
    assign at_last = (cnt == LAST_IDX);
    assign m_last  = m_valid && at_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= hs && at_last;
            if (hs) begin
                cnt <= at_last ? '0 : cnt + 1'b1;
            end
        end
    end

`ifdef DENORM_SAT_CNT_EN
    // The first handshake of a new frame restarts the count with its own clamp flag.
    logic new_frame;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
            new_frame <= 1'b0;
        end else if (hs) begin
            new_frame <= at_last;
            if (new_frame) begin
                sat_count <= {15'b0, s2_q.clamp};
            end else if (s2_q.clamp && sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_denormalize.sv
// Scoreboard bench for denormalize: directed vectors, backpressure, random flow, mid-frame reset.
// A second instance with FRAME_LEN=1 shares the input stream and flow control.
`timescale 1ns/1ps
module tb_denormalize;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0;
    logic        m_ready = 1'b1;
    logic        s_ready, m_valid, m_last, frame_done;
    logic [7:0]  m_data;
    logic        s_ready1, m_valid1, m_last1, frame_done1;
    logic [7:0]  m_data1;
`ifdef DENORM_SAT_CNT_EN
    logic [15:0] sat_count, sat_count1;
`endif

    always #5 clk = ~clk;

    denormalize dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
`ifdef DENORM_SAT_CNT_EN
        .sat_count(sat_count),
`endif
        .frame_done(frame_done)
    );

    denormalize #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
`ifdef DENORM_SAT_CNT_EN
        .sat_count(sat_count1),
`endif
        .frame_done(frame_done1)
    );

    typedef struct {
        logic [7:0] pix;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   mr_mode = 0;
    bit   gaps = 0;
    bit   lat_chk = 0;
    int   out_idx = 0;
    int   fd_cnt = 0;
    int   base;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [7:0] model(input logic [15:0] d);
        int v;
        int q;
        v = int'($signed(d));
        q = (v + 64) >>> 7;
        if (q < 0) return 8'd0;
        if (q > 255) return 8'd255;
        return q[7:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (mr_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    task automatic push_exp(input logic [7:0] e);
        exp_t t;
        t.pix = e;
        t.cyc = cyc;
        t.lat = lat_chk;
        exp_q.push_back(t);
    endtask

    // Called at posedge+1; returns at posedge+1 with s_valid still high.
    task automatic send(input logic [15:0] d, input logic [7:0] e);
        int budget;
        budget = 500;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                push_exp(e);
                break;
            end
            budget--;
            if (budget == 0) begin
                chk("send_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        s_valid = 1'b0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    bit         prev_lasths = 0, prev_hs1 = 0, prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin : mon
        exp_t e;
        bit   exp_last;
        if (!rst_n) begin
            out_idx = 0; prev_lasths = 0; prev_hs1 = 0; prev_stall = 0;
        end else begin
            exp_last = ((out_idx % 784) == 783);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (frame_done || prev_lasths) chk("frame_done", frame_done, prev_lasths);
            if (frame_done) fd_cnt++;
            if (frame_done1 || prev_hs1) chk("frame_done_fl1", frame_done1, prev_hs1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %0d, expected no output at %0t", m_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", m_data, e.pix);
                    chk("last", m_last, exp_last);
                    chk("data_fl1", m_data1, e.pix);
                    chk("last_fl1", m_valid1 && m_last1, 1);
                    if (e.lat) chk("latency", cyc - e.cyc, 2);
                end
                out_idx++;
            end
            prev_lasths = m_valid && m_ready && exp_last;
            prev_hs1    = m_valid1 && m_ready;
            prev_stall  = m_valid && !m_ready;
            prev_data   = m_data;
            prev_last   = m_last;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        bit          full;

        // Reset values, with garbage offered on the input.
        s_valid = 1'b1;
        s_data  = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk); #1;

        // Rounding with m_ready high and exact latency.
        lat_chk = 1;
        send(16'h3F80, 8'd127); idle(3);
        send(16'd64,   8'd1);   idle(3);
        send(16'd63,   8'd0);   idle(3);
        send(16'd0,    8'd0);   idle(3);
        lat_chk = 0;

        // Saturation.
        send(16'd32767, 8'd255);
        send(16'd32704, 8'd255);
        send(16'd32639, 8'd255);
        send(16'hFFFF,  8'd0);
        send(16'h8000,  8'd0);
        drain();
`ifdef DENORM_SAT_CNT_EN
        chk("sat_count", sat_count, 3);
`endif

        // Backpressure: 10 back-to-back elements, 5-cycle stall after the third output.
        base = out_idx;
        fork
            begin
                for (int i = 0; i < 10; i++) send(16'(i * 25 * 128 + 64), 8'(i * 25 + 1));
                s_valid = 1'b0;
            end
            begin : staller
                int n;
                n = 0;
                while (out_idx < base + 3 && n < 200) begin @(negedge clk); n++; end
                mr_mode = 2;
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_s_ready_full", s_ready, 0);
                chk("bp_m_valid_held", m_valid, 1);
                mr_mode = 0;
            end
        join
        drain();
        chk("bp_count", out_idx - base, 10);

        // Random flow over three frames.
        pulse_reset();
        fd_cnt  = 0;
        mr_mode = 1;
        gaps    = 1;
        for (int i = 0; i < 3 * 784; i++) begin
            d = 16'($urandom);
            send(d, model(d));
        end
        drain();
        chk("rand_out_count", out_idx, 3 * 784);
        chk("rand_frame_done_count", fd_cnt, 3);

        // Mid-frame reset with both stages full.
        for (int i = 0; i < 2000 && out_idx < 300; i++) begin
            d = 16'($urandom);
            send(d, model(d));
        end
        s_valid = 1'b0;
        mr_mode = 2;
        @(posedge clk); #2;
        full = 0;
        for (int k = 0; k < 10 && !full; k++) begin
            d = 16'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            @(negedge clk);
            if (s_ready) push_exp(model(d));
            else full = 1;
            @(posedge clk); #1;
        end
        chk("rst_fill_full", full, 1);
        pulse_reset();
        mr_mode = 0;
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_frame_done", frame_done, 0);
        @(posedge clk); #1;
        fd_cnt  = 0;
        mr_mode = 1;
        for (int i = 0; i < 784; i++) begin
            d = 16'($urandom);
            send(d, model(d));
        end
        drain();
        chk("post_rst_out_count", out_idx, 784);
        chk("post_rst_frame_done_count", fd_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
